// File: rtl/touch_report_pkg.sv
// Shared constants, FSM state type and report byte packing for the touch report UART transmitter.
package touch_report_pkg;

  localparam int REPORT_BYTES = 5;
  localparam int HDR_BIT      = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // Byte 0 carries the sync/header bit; the coordinate bytes keep bit 7 clear.
  function automatic logic [7:0] report_byte(input logic [2:0]  idx,
                                             input logic        pen,
                                             input logic [11:0] x,
                                             input logic [11:0] y);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      3'd0: begin
        b[HDR_BIT] = 1'b1;
        b[0]       = pen;
      end
      3'd1:    b = {1'b0, x[6:0]};
      3'd2:    b = {3'b000, x[11:7]};
      3'd3:    b = {1'b0, y[6:0]};
      3'd4:    b = {3'b000, y[11:7]};
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/touch_report_uart_tx_byte.sv
// 8N1 bit engine: sends one byte per accepted transfer; a byte offered in the
// last stop-bit cycle follows with no idle gap.
// state   | meaning
// IDLE    | line idle (txd=1), waiting for a byte
// START   | start bit (txd=0)
// DATA    | eight data bits, LSB first
// STOP    | stop bit (txd=1); next byte may be taken on its last cycle
module uart_tx_byte
  import touch_report_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byte_valid_i,
  input  logic [7:0] byte_data_i,
  output logic       byte_ready_o,
  output logic       idle_o,
  output logic       txd_o
);

  localparam int              CW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_t     state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          txd_q, txd_d;
  logic          bit_end;
  logic          take;

  assign bit_end      = (baud_q == BAUD_LAST);
  assign idle_o       = (state_q == ST_IDLE);
  assign byte_ready_o = idle_o || ((state_q == ST_STOP) && bit_end);
  assign take         = byte_valid_i && byte_ready_o;
  assign txd_o        = txd_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    txd_d   = txd_q;

    if (state_q != ST_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + CW'(1);
    end

    case (state_q)
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          bit_d   = 3'd0;
          txd_d   = shreg_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            txd_d   = shreg_q[1];
            shreg_d = {1'b0, shreg_q[7:1]};
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          state_d = ST_IDLE;
        end
      end
      default: ;
    endcase

    // Taking a byte overrides the STOP->IDLE exit to keep bytes back-to-back.
    if (take) begin
      state_d = ST_START;
      baud_d  = '0;
      txd_d   = 1'b0;
      shreg_d = byte_data_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shreg_q <= 8'h00;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      txd_q   <= txd_d;
    end
  end

endmodule

// File: rtl/touch_report_uart_tx.sv
// Touch report transmitter: latches one pen/X/Y report and streams it as five
// back-to-back 8N1 bytes through the byte engine.
module touch_report_uart_tx
  import touch_report_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        report_valid,
  output logic        report_ready,
  input  logic        pen_down,
  input  logic [11:0] x,
  input  logic [11:0] y,
  output logic        txd,
  output logic        busy
);

  logic [24:0] hold_q, hold_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic        eng_idle;
  logic        eng_ready;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        last_byte;

  assign last_byte    = (byte_idx_q == 3'(REPORT_BYTES - 1));
  assign report_ready = eng_idle;
  assign busy         = !eng_idle;

  // B0 comes straight from the inputs so its start bit can begin on the accept edge.
  always_comb begin
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    hold_d     = hold_q;
    byte_idx_d = byte_idx_q;

    if (eng_idle) begin
      byte_valid = report_valid;
      byte_data  = report_byte(3'd0, pen_down, x, y);
    end else begin
      byte_valid = !last_byte;
      byte_data  = report_byte(byte_idx_q + 3'd1, hold_q[24], hold_q[23:12], hold_q[11:0]);
    end

    if (byte_valid && eng_ready) begin
      if (eng_idle) begin
        hold_d     = {pen_down, x, y};
        byte_idx_d = 3'd0;
      end else begin
        byte_idx_d = byte_idx_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q     <= '0;
      byte_idx_q <= 3'd0;
    end else begin
      hold_q     <= hold_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk         (clk),
    .reset       (reset),
    .byte_valid_i(byte_valid),
    .byte_data_i (byte_data),
    .byte_ready_o(eng_ready),
    .idle_o      (eng_idle),
    .txd_o       (txd)
  );

endmodule

// File: tb/tb_touch_report_uart_tx.sv
// Directed bench for touch_report_uart_tx at 4 clocks per bit; txd and ready
// are logged per cycle and frames are decoded from the log against hand-computed bytes.
module tb_touch_report_uart_tx;

  localparam int CPB  = 4;
  localparam int LOGN = 8192;

  logic        clk;
  logic        reset;
  logic        report_valid;
  logic        report_ready;
  logic        pen_down;
  logic [11:0] x;
  logic [11:0] y;
  logic        txd;
  logic        busy;

  int n_chk;
  int n_fail;
  int cyc;
  int acc_q[$];
  logic txd_log [0:LOGN-1];
  logic rdy_log [0:LOGN-1];

  touch_report_uart_tx #(
    .CLK_HZ      (50_000_000),
    .BAUD        (9600),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .report_valid(report_valid),
    .report_ready(report_ready),
    .pen_down    (pen_down),
    .x           (x),
    .y           (y),
    .txd         (txd),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && report_valid && report_ready) acc_q.push_back(cyc + 1);
  end

  always @(negedge clk) begin
    if (cyc < LOGN) begin
      txd_log[cyc] <= txd;
      rdy_log[cyc] <= report_ready;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic log_txd(input int i);
    return (i >= 0 && i < LOGN) ? txd_log[i] : 1'bx;
  endfunction

  function automatic logic log_rdy(input int i);
    return (i >= 0 && i < LOGN) ? rdy_log[i] : 1'bx;
  endfunction

  // 10-bit frame sampled mid-bit: bit0 = start, bits 8:1 = data, bit9 = stop.
  function automatic logic [9:0] get_frame(input int base);
    logic [9:0] f;
    for (int i = 0; i < 10; i++) f[i] = log_txd(base + CPB * i + 2);
    return f;
  endfunction

  task automatic check_report(input string tag, input int a, input logic [39:0] bytes);
    int unstable;
    logic [7:0] eb;
    for (int b = 0; b < 5; b++) begin
      eb = bytes[39 - 8 * b -: 8];
      check_eq($sformatf("%s_B%0d", tag, b), {22'd0, get_frame(a + 40 * b)}, {22'd0, 1'b1, eb, 1'b0});
    end
    unstable = 0;
    for (int c = 0; c < 50; c++)
      for (int s = 0; s < CPB; s++)
        if (log_txd(a + CPB * c + s) !== log_txd(a + CPB * c + 2)) unstable++;
    check_eq($sformatf("%s_cells", tag), unstable, 0);
  endtask

  task automatic wait_acc(input int n, output int a);
    for (int i = 0; i < 600 && acc_q.size() == n; i++) @(negedge clk);
    check_eq("accept_seen", acc_q.size(), n + 1);
    a = (acc_q.size() > n) ? acc_q[n] : 0;
  endtask

  task automatic send(input logic p, input logic [11:0] xx, input logic [11:0] yy,
                      input bit keep, output int a);
    int n;
    n = acc_q.size();
    @(negedge clk);
    pen_down = p;
    x = xx;
    y = yy;
    report_valid = 1'b1;
    wait_acc(n, a);
    if (!keep) report_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int a, a2, viol, zeros, n;
    clk = 1'b0;
    reset = 1'b1;
    report_valid = 1'b0;
    pen_down = 1'b0;
    x = 12'h000;
    y = 12'h000;
    n_chk = 0;
    n_fail = 0;
    cyc = 0;

    #1;
    check_eq("rst_txd", txd, 1'b1);
    check_eq("rst_ready", report_ready, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // 1: idle line after reset
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || report_ready !== 1'b1 || busy !== 1'b0) viol++;
    end
    check_eq("idle_100", viol, 0);

    // 2: basic report, frame length and ready timing
    send(1'b1, 12'hABC, 12'h123, 1'b0, a);
    repeat (210) @(negedge clk);
    check_report("s2", a, 40'h81_3C_15_23_02);
    check_eq("s2_start_first", log_txd(a), 1'b0);
    check_eq("s2_busy_first", log_rdy(a), 1'b0);
    check_eq("s2_last_stop", log_txd(a + 199), 1'b1);
    check_eq("s2_rdy_last", log_rdy(a + 199), 1'b0);
    check_eq("s2_rdy_after", log_rdy(a + 200), 1'b1);
    check_eq("s2_idle_after", log_txd(a + 200), 1'b1);

    // 3: inputs scrambled after accept must not affect the frame
    send(1'b0, 12'h000, 12'hFFF, 1'b0, a);
    for (int i = 0; i < 205; i++) begin
      x = 12'($urandom_range(0, 4095));
      y = 12'($urandom_range(0, 4095));
      pen_down = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    check_report("s3", a, 40'h80_00_00_7F_1F);

    // 4: valid held high across two reports
    send(1'b1, 12'h7E1, 12'h0C4, 1'b1, a);
    send(1'b1, 12'h555, 12'h2AA, 1'b0, a2);
    repeat (210) @(negedge clk);
    check_eq("s4_spacing", a2 - a, 201);
    check_eq("s4_gap_idle", log_txd(a + 200), 1'b1);
    check_eq("s4_second_start", log_txd(a + 201), 1'b0);
    check_report("s4a", a, 40'h81_61_0F_44_01);
    check_report("s4b", a2, 40'h81_55_0A_2A_05);

    // 5: reset during data bits of B2 (x=0 so the line is low there)
    send(1'b1, 12'h000, 12'h3C5, 1'b0, a);
    repeat (89) @(negedge clk);
    check_eq("s5_pre_low", txd, 1'b0);
    reset = 1'b1;
    #1;
    check_eq("s5_txd_async", txd, 1'b1);
    check_eq("s5_ready_rst", report_ready, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n = cyc;
    repeat (60) @(negedge clk);
    zeros = 0;
    for (int i = n; i < n + 55; i++) if (log_txd(i) !== 1'b1) zeros++;
    check_eq("s5_no_resume", zeros, 0);
    check_eq("s5_ready_after", report_ready, 1'b1);
    send(1'b0, 12'h7E1, 12'h0C4, 1'b0, a);
    repeat (210) @(negedge clk);
    check_report("s5", a, 40'h80_61_0F_44_01);

    // 6: valid pulse while busy is dropped
    send(1'b1, 12'h001, 12'h002, 1'b0, a);
    n = acc_q.size();
    repeat (49) @(negedge clk);
    check_eq("s6_ready_busy", report_ready, 1'b0);
    check_eq("s6_busy", busy, 1'b1);
    pen_down = 1'b0;
    x = 12'hFFF;
    y = 12'hFFF;
    report_valid = 1'b1;
    @(negedge clk);
    report_valid = 1'b0;
    repeat (240) @(negedge clk);
    check_report("s6", a, 40'h81_01_00_02_00);
    check_eq("s6_no_accept", acc_q.size(), n);
    zeros = 0;
    for (int i = a + 200; i < a + 280; i++) if (log_txd(i) !== 1'b1) zeros++;
    check_eq("s6_no_frame", zeros, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
